// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush controller for the PC register and the four pipeline
// registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves three hazard sources,
// highest priority first:
//   1. multi-cycle data-memory access (freeze the whole front of the pipe and
//      bubble MEM/WB so the access result is written back only once)
//   2. taken branch/jump in EX (squash IF/ID and ID/EX)
//   3. load-use dependency between EX load and ID reader (one-cycle bubble)
// All stall/flush lines are combinational so they take effect at the same
// rising edge that would otherwise advance the pipeline.
//
// Parameters:
//   MEM_LAT    data-memory latency in cycles (>=1; 1 never freezes)
//   WD_SEL_MEM rf_wd_sel code selecting memory data (identifies loads)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   global_en                  run enable; when low state holds, outputs 0
//   id_rf_ra0/1, id_use_ra0/1  ID-stage source registers and their use flags
//   ex_rf_we/wa/wd_sel         EX-stage destination info
//   ex_br_taken                EX resolved a taken branch (PC redirect)
//   mem_req                    MEM stage holds a valid dmem access
//   stall_*                    hold PC / IF/ID / ID/EX / EX/MEM
//   flush_*                    bubble IF/ID / ID/EX / MEM/WB
//   ctrl_state                 FSM state (RUN=0, MWAIT=1) for debug display
//   perf_stall_cnt/flush_cnt   performance counters
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the two 32-bit
// performance counters; otherwise both ports read 0 and no flops exist.

module pipeline_hazard_ctrl #(
  parameter int          MEM_LAT    = 2,
  parameter logic [1:0]  WD_SEL_MEM = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        global_en,
  input  logic [4:0]  id_rf_ra0,
  input  logic [4:0]  id_rf_ra1,
  input  logic        id_use_ra0,
  input  logic        id_use_ra1,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_wa,
  input  logic [1:0]  ex_rf_wd_sel,
  input  logic        ex_br_taken,
  input  logic        mem_req,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_mem_wb,
  output logic [1:0]  ctrl_state,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam bit MULTI_CYCLE = (MEM_LAT > 1);
  // First MWAIT value: the RUN cycle that detects the access is itself the
  // first freeze cycle, and cnt reaching 0 marks the release cycle.
  localparam logic [CW-1:0] CNT_INIT = MULTI_CYCLE ? CW'(MEM_LAT - 2) : '0;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    MWAIT = 2'b01
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            mem_freeze;
  logic            load_use;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and memory freeze. Transitions only happen on enabled cycles;
  // a mem_req in the MWAIT release cycle belongs to the finishing access and
  // therefore does not restart the wait.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mem_freeze = 1'b0;
    case (state_reg)
      RUN: begin
        if (mem_req && MULTI_CYCLE) begin
          mem_freeze = 1'b1;
          if (global_en) begin
            state_next = MWAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      MWAIT: begin
        if (cnt_reg != '0) begin
          mem_freeze = 1'b1;
          if (global_en) cnt_next = cnt_reg - 1'b1;
        end else if (global_en) begin
          state_next = RUN;
        end
      end
      default: begin
        if (global_en) state_next = RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load-use detection: one comparator per ID source port. x0 is hard-wired
  // to zero, so a load targeting it can never create a dependency.
  // ---------------------------------------------------------------------------
  logic [4:0] id_ra  [2];
  logic [1:0] id_use;
  logic [1:0] src_hit;

  assign id_ra[0] = id_rf_ra0;
  assign id_ra[1] = id_rf_ra1;
  assign id_use   = {id_use_ra1, id_use_ra0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src_cmp
      assign src_hit[gi] = id_use[gi] && (id_ra[gi] == ex_rf_wa);
    end
  endgenerate

  assign load_use = ex_rf_we && (ex_rf_wd_sel == WD_SEL_MEM) &&
                    (ex_rf_wa != 5'd0) && (|src_hit);

  // ---------------------------------------------------------------------------
  // Stall/flush outputs, prioritised. A branch seen during a freeze is not
  // acted on; it stays in EX and is replayed once the freeze releases.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_mem_wb = 1'b0;
    if (global_en) begin
      if (mem_freeze) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        flush_mem_wb = 1'b1;
      end else if (ex_br_taken) begin
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
      end else if (load_use) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
      end
    end
  end

  assign ctrl_state = state_reg;

  // ---------------------------------------------------------------------------
  // Performance counters. flush_if_id is driven only by a taken branch, so it
  // identifies branch-driven flush cycles.
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_reg, perf_flush_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      if (global_en && stall_pc)    perf_stall_reg <= perf_stall_reg + 32'd1;
      if (global_en && flush_if_id) perf_flush_reg <= perf_flush_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_reg;
  assign perf_flush_cnt = perf_flush_reg;
`else
  assign perf_stall_cnt = 32'b0;
  assign perf_flush_cnt = 32'b0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. Three instances with MEM_LAT = 1, 3 and
// 4 share one set of inputs. A reference model tracks each memory access as
// a position inside an access window of MEM_LAT cycles and derives the
// expected outputs from the hazard priority rules.

module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        global_en;
  logic [4:0]  id_rf_ra0, id_rf_ra1, ex_rf_wa;
  logic        id_use_ra0, id_use_ra1, ex_rf_we, ex_br_taken, mem_req;
  logic [1:0]  ex_rf_wd_sel;

  logic [2:0]  stall_pc_w, stall_if_id_w, stall_id_ex_w, stall_ex_mem_w;
  logic [2:0]  flush_if_id_w, flush_id_ex_w, flush_mem_wb_w;
  logic [1:0]  ctrl_state_w [3];
  logic [31:0] perf_stall_w [3];
  logic [31:0] perf_flush_w [3];

  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state per instance.
  int          lat [3] = '{1, 3, 4};
  int          pos [3];            // -1 idle, else cycle index inside access window
  logic [31:0] m_stall [3];
  logic [31:0] m_flush [3];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_LAT(1), .WD_SEL_MEM(2'b10)) u_l1 (
    .clk(clk), .rst_n(rst_n), .global_en(global_en),
    .id_rf_ra0(id_rf_ra0), .id_rf_ra1(id_rf_ra1),
    .id_use_ra0(id_use_ra0), .id_use_ra1(id_use_ra1),
    .ex_rf_we(ex_rf_we), .ex_rf_wa(ex_rf_wa), .ex_rf_wd_sel(ex_rf_wd_sel),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req),
    .stall_pc(stall_pc_w[0]), .stall_if_id(stall_if_id_w[0]),
    .stall_id_ex(stall_id_ex_w[0]), .stall_ex_mem(stall_ex_mem_w[0]),
    .flush_if_id(flush_if_id_w[0]), .flush_id_ex(flush_id_ex_w[0]),
    .flush_mem_wb(flush_mem_wb_w[0]), .ctrl_state(ctrl_state_w[0]),
    .perf_stall_cnt(perf_stall_w[0]), .perf_flush_cnt(perf_flush_w[0])
  );

  pipeline_hazard_ctrl #(.MEM_LAT(3), .WD_SEL_MEM(2'b10)) u_l3 (
    .clk(clk), .rst_n(rst_n), .global_en(global_en),
    .id_rf_ra0(id_rf_ra0), .id_rf_ra1(id_rf_ra1),
    .id_use_ra0(id_use_ra0), .id_use_ra1(id_use_ra1),
    .ex_rf_we(ex_rf_we), .ex_rf_wa(ex_rf_wa), .ex_rf_wd_sel(ex_rf_wd_sel),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req),
    .stall_pc(stall_pc_w[1]), .stall_if_id(stall_if_id_w[1]),
    .stall_id_ex(stall_id_ex_w[1]), .stall_ex_mem(stall_ex_mem_w[1]),
    .flush_if_id(flush_if_id_w[1]), .flush_id_ex(flush_id_ex_w[1]),
    .flush_mem_wb(flush_mem_wb_w[1]), .ctrl_state(ctrl_state_w[1]),
    .perf_stall_cnt(perf_stall_w[1]), .perf_flush_cnt(perf_flush_w[1])
  );

  pipeline_hazard_ctrl #(.MEM_LAT(4), .WD_SEL_MEM(2'b10)) u_l4 (
    .clk(clk), .rst_n(rst_n), .global_en(global_en),
    .id_rf_ra0(id_rf_ra0), .id_rf_ra1(id_rf_ra1),
    .id_use_ra0(id_use_ra0), .id_use_ra1(id_use_ra1),
    .ex_rf_we(ex_rf_we), .ex_rf_wa(ex_rf_wa), .ex_rf_wd_sel(ex_rf_wd_sel),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req),
    .stall_pc(stall_pc_w[2]), .stall_if_id(stall_if_id_w[2]),
    .stall_id_ex(stall_id_ex_w[2]), .stall_ex_mem(stall_ex_mem_w[2]),
    .flush_if_id(flush_if_id_w[2]), .flush_id_ex(flush_id_ex_w[2]),
    .flush_mem_wb(flush_mem_wb_w[2]), .ctrl_state(ctrl_state_w[2]),
    .perf_stall_cnt(perf_stall_w[2]), .perf_flush_cnt(perf_flush_w[2])
  );

  // Observed vector: {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
  //                   flush_if_id, flush_id_ex, flush_mem_wb, ctrl_state}
  function automatic logic [8:0] observed(input int k);
    return {stall_pc_w[k], stall_if_id_w[k], stall_id_ex_w[k], stall_ex_mem_w[k],
            flush_if_id_w[k], flush_id_ex_w[k], flush_mem_wb_w[k], ctrl_state_w[k]};
  endfunction

  // Access window of L cycles: positions 0..L-2 freeze, position L-1 releases.
  // Position 0 is spent in RUN, the remaining positions are shown as MWAIT.
  function automatic logic [8:0] expected(input int k);
    bit freeze, lu, in_wait;
    in_wait = (pos[k] >= 1);
    freeze  = (lat[k] > 1) && ((pos[k] < 0 && mem_req) ||
                               (in_wait && pos[k] <= lat[k] - 2));
    lu = ex_rf_we && ex_rf_wd_sel == 2'b10 && ex_rf_wa != 0 &&
         ((id_use_ra0 && id_rf_ra0 == ex_rf_wa) ||
          (id_use_ra1 && id_rf_ra1 == ex_rf_wa));
    if (!global_en) return {7'b0, 1'b0, in_wait};
    if (freeze)      return {4'b1111, 3'b001, 1'b0, in_wait};
    if (ex_br_taken) return {4'b0000, 3'b110, 1'b0, in_wait};
    if (lu)          return {4'b1100, 3'b010, 1'b0, in_wait};
    return {7'b0, 1'b0, in_wait};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      pos[k]     = -1;
      m_stall[k] = 32'd0;
      m_flush[k] = 32'd0;
    end
  endtask

  // One clock: compare at the falling edge, then advance the model through
  // the rising edge. Inputs are changed by the caller 1 time unit after.
  task automatic step(input string tag);
    logic [8:0] exp_v, obs_v;
    logic [31:0] exp_s, exp_f;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_v = expected(k);
      obs_v = observed(k);
      n_checks++;
      assert (obs_v === exp_v) else begin
        n_fail++;
        $error("FAIL %s L%0d outputs: observed=%b expected=%b", tag, lat[k], obs_v, exp_v);
      end
`ifdef HAZARD_PERF_CNT_EN
      exp_s = m_stall[k];
      exp_f = m_flush[k];
`else
      exp_s = 32'd0;
      exp_f = 32'd0;
`endif
      n_checks++;
      assert (perf_stall_w[k] === exp_s && perf_flush_w[k] === exp_f) else begin
        n_fail++;
        $error("FAIL %s L%0d perf: observed=%0d/%0d expected=%0d/%0d",
               tag, lat[k], perf_stall_w[k], perf_flush_w[k], exp_s, exp_f);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_v = expected(k);
      if (exp_v[8]) m_stall[k] = m_stall[k] + 32'd1;
      if (exp_v[4]) m_flush[k] = m_flush[k] + 32'd1;
      if (global_en) begin
        if (pos[k] < 0) begin
          if (mem_req && lat[k] > 1) pos[k] = 1;
        end else begin
          pos[k] = pos[k] + 1;
          if (pos[k] > lat[k] - 1) pos[k] = -1;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    global_en = 1'b1;
    id_rf_ra0 = 5'd0; id_rf_ra1 = 5'd0; id_use_ra0 = 1'b0; id_use_ra1 = 1'b0;
    ex_rf_we = 1'b0; ex_rf_wa = 5'd0; ex_rf_wd_sel = 2'b00;
    ex_br_taken = 1'b0; mem_req = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] wa);
    ex_rf_we = 1'b1; ex_rf_wa = wa; ex_rf_wd_sel = 2'b10;
    id_rf_ra1 = wa; id_use_ra1 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      assert (observed(k) === 9'd0) else begin
        n_fail++;
        $error("FAIL reset L%0d: observed=%b expected=%b", lat[k], observed(k), 9'd0);
      end
    end
    #21 rst_n = 1'b1;
    #2;
    repeat (2) step("idle");

    // Load-use on ra1, then the hazard clears as the load moves on.
    set_load_use(5'd5);
    step("load_use");
    idle_inputs();
    step("load_use_clear");
    // Load-use on ra0 with ra1 unused.
    ex_rf_we = 1'b1; ex_rf_wa = 5'd9; ex_rf_wd_sel = 2'b10;
    id_rf_ra0 = 5'd9; id_use_ra0 = 1'b1;
    step("load_use_ra0");
    // Non-load writer does not stall.
    ex_rf_wd_sel = 2'b01;
    step("alu_dep");
    idle_inputs();
    // x0 destination never stalls.
    set_load_use(5'd0);
    step("load_use_x0");
    idle_inputs();

    // Branch beats load-use.
    set_load_use(5'd7);
    ex_br_taken = 1'b1;
    step("branch_vs_lu");
    idle_inputs();
    step("idle");

    // Memory access held high through the freeze and its release.
    mem_req = 1'b1;
    repeat (3) step("mem_wait");
    mem_req = 1'b0;
    repeat (2) step("mem_after");

    // Branch arriving during freeze is deferred until release.
    mem_req = 1'b1;
    ex_br_taken = 1'b1;
    repeat (4) step("freeze_vs_br");
    idle_inputs();
    step("idle");

    // Enable dropped mid-wait for three cycles.
    mem_req = 1'b1;
    step("en_start");
    global_en = 1'b0;
    repeat (3) step("en_off");
    global_en = 1'b1;
    repeat (4) step("en_resume");
    idle_inputs();
    step("idle");

    // Asynchronous reset during MWAIT (L4 instance freezes for 3 cycles).
    mem_req = 1'b1;
    step("pre_reset");
    mem_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      assert (observed(k) === 9'd0) else begin
        n_fail++;
        $error("FAIL async_reset L%0d: observed=%b expected=%b", lat[k], observed(k), 9'd0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) step("post_reset");

    // Randomised traffic with a narrow register range to hit dependencies.
    for (int i = 0; i < 400; i++) begin
      global_en    = ($urandom_range(0, 9) != 0);
      id_rf_ra0    = 5'($urandom_range(0, 3));
      id_rf_ra1    = 5'($urandom_range(0, 3));
      id_use_ra0   = 1'($urandom_range(0, 1));
      id_use_ra1   = 1'($urandom_range(0, 1));
      ex_rf_we     = 1'($urandom_range(0, 1));
      ex_rf_wa     = 5'($urandom_range(0, 3));
      ex_rf_wd_sel = 2'($urandom_range(0, 3));
      ex_br_taken  = ($urandom_range(0, 4) == 0);
      mem_req      = ($urandom_range(0, 3) == 0);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the four intersegment registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Detects load-use hazards, taken-branch redirects and multi-cycle data-memory accesses.
- Drives per-segment stall/flush lines so every pipeline register freezes or bubbles in lockstep.
- Contains a small FSM plus a wait counter that sequences memory-latency freezes.

Parameters:
- MEM_LAT, 2, data-memory access latency in cycles, ≥1; 1 means single-cycle memory and never freezes.
- WD_SEL_MEM, 2'b10, rf_wd_sel code meaning "write-back data from memory" (load).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- global_en  in  1  PDU run enable, shared with PC and segment en
- id_rf_ra0  in  5  ID-stage source register 0
- id_rf_ra1  in  5  ID-stage source register 1
- id_use_ra0  in  1  ID instruction reads ra0
- id_use_ra1  in  1  ID instruction reads ra1
- ex_rf_we  in  1  EX instruction writes the register file
- ex_rf_wa  in  5  EX destination register
- ex_rf_wd_sel  in  2  EX write-back source select
- ex_br_taken  in  1  EX resolved a taken branch/jump (PC redirect)
- mem_req  in  1  MEM stage holds a valid dmem access
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID
- stall_id_ex  out  1  hold ID/EX
- stall_ex_mem  out  1  hold EX/MEM
- flush_if_id  out  1  bubble IF/ID
- flush_id_ex  out  1  bubble ID/EX
- flush_mem_wb  out  1  bubble MEM/WB
- ctrl_state  out  2  FSM state, for debug/PDU display
- perf_stall_cnt  out  32  see Optional Feature
- perf_flush_cnt  out  32  see Optional Feature

Behaviour:
- Registered state: FSM state {RUN=2'b00, MWAIT=2'b01} and wait counter cnt (width $clog2(MEM_LAT)+1).
- All stall/flush outputs are combinational from state, cnt and inputs, so they act at the same rising edge.
- Reset (rst_n=0, asynchronous): state=RUN, cnt=0, perf counters=0. Reset asserted mid-MWAIT aborts the wait immediately. With all inputs 0, every output is 0.
- global_en=0: state and cnt hold, all stall/flush outputs forced 0 (segments are already gated by en).
- mem_freeze = (state==RUN && mem_req && MEM_LAT>1) || (state==MWAIT && cnt!=0).
  - Transitions: RUN with mem_req and MEM_LAT>1 → MWAIT, cnt←MEM_LAT-2. MWAIT with cnt!=0 → cnt←cnt-1. MWAIT with cnt==0 → RUN (release cycle, no freeze).
  - A mem_req seen in the MWAIT release cycle does not retrigger the wait.
  - Total freeze length is MEM_LAT-1 cycles per access.
- load_use = ex_rf_we && ex_rf_wd_sel==WD_SEL_MEM && ex_rf_wa!=0 && ((id_use_ra0 && id_rf_ra0==ex_rf_wa) || (id_use_ra1 && id_rf_ra1==ex_rf_wa)).
- Output priority, highest first:
  1. mem_freeze: stall_pc=stall_if_id=stall_id_ex=stall_ex_mem=1, flush_mem_wb=1 (no duplicate write-back). All other flushes 0; a taken branch held in EX is replayed after the freeze.
  2. ex_br_taken: flush_if_id=flush_id_ex=1, no stalls. Any simultaneous load_use is ignored because the ID instruction is squashed.
  3. load_use: stall_pc=stall_if_id=1, flush_id_ex=1 (one-cycle bubble). The hazard clears naturally as the load advances to MEM.
  4. Otherwise all 0.
- Register x0 never causes a load-use stall.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
  - Defined: perf_stall_cnt increments on each global_en cycle with stall_pc=1; perf_flush_cnt increments on each global_en cycle with ex_br_taken-driven flush. Both are 32-bit, wrap at 2^32-1→0, and clear on reset.
  - Undefined: both ports are tied to 32'b0 and no counter flops exist.

Test Plan:
- Reset: rst_n=0 during MWAIT with MEM_LAT=4 → ctrl_state=0 and all stall/flush=0 asynchronously. After release, all outputs stay 0 with idle inputs.
- Load-use: ex_rf_we=1, ex_rf_wa=5, ex_rf_wd_sel=2'b10, id_rf_ra1=5, id_use_ra1=1 → stall_pc=stall_if_id=flush_id_ex=1 for exactly 1 cycle. Repeating with ex_rf_wa=0 → no stall.
- Branch vs load-use: ex_br_taken=1 together with load-use condition → flush_if_id=flush_id_ex=1, stall_pc=0.
- Memory latency: MEM_LAT=3, mem_req=1 one cycle then held by freeze → stalls+flush_mem_wb high 2 cycles, ctrl_state 0→1→1→0, then released. MEM_LAT=1 → no freeze.
- Freeze vs branch: ex_br_taken=1 during freeze → no flush until the release cycle, then flush_if_id=flush_id_ex=1.
- global_en=0 mid-MWAIT for 3 cycles → outputs 0 and cnt holds. On re-enable the remaining freeze cycles complete. With HAZARD_PERF_CNT_EN, perf_stall_cnt counts only enabled stall cycles.
